rr_sel24: RTL and testbench
===========================

# rr_sel24

Four-requester round-robin select sequencer that drives the select/enable inputs (`a`, `b`, `en`) of the 2:4 one-hot decoder, so that decoder output `y[i]` acts as the grant for requester `i`. The block picks the next active requester in rotating order and holds the grant until the owner signals `done`, drops its request, or a hold-time limit expires. A guaranteed one-cycle bubble separates consecutive grants, so the decoder never switches between two one-hot outputs without passing through all-zero.

## Interface
- `HOLD_MAX`, default 15: maximum number of cycles `en` may stay high for one grant. Legal range is 1 to 2^CW-1.
- `CW`, default 4: width of the hold counter.

- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req`, input, [3:0]: request vector; bit `i` is requester `i`.
- `done`, input, 1: the current grant owner releases the grant.
- `a`, output, 1: MSB of the granted index; drives decoder `a`.
- `b`, output, 1: LSB of the granted index; drives decoder `b`.
- `en`, output, 1: grant valid; drives decoder `en`.
- `busy`, output, 1: high while in GRANT; equals `en`.
- `timeout`, output, 1: one-cycle pulse when a grant is force-released.

## Operation
- All outputs and state are registered.
- **Reset values:** `a=0`, `b=0`, `en=0`, `busy=0`, `timeout=0`, state = IDLE, `cnt=0`, `last=3`. With `last=3`, index 0 has first priority after reset.
- **State IDLE:**
  - If `req != 0`, select the first set bit searching `last+1`, `last+2`, `last+3`, `last` (mod 4).
  - On the next edge: `{a,b}` = that index, `en=1`, `cnt=0`, go to GRANT.
  - If `req == 0`, stay in IDLE. `a` and `b` hold their previous values and `en=0`.
- **State GRANT (owner index g = {a,b}):**
  - **Release conditions, in priority order:**
    - `done=1`: normal release.
    - `req[g]=0`: normal release.
    - `cnt == HOLD_MAX-1`: forced release; set `timeout=1`.
  - **On any release, at the next edge:** `en=0`, `last=g`, go to IDLE. `a` and `b` keep g.
  - **Otherwise:** `cnt` increments by 1 and the block stays in GRANT.
  - `req` bits other than g are ignored during GRANT.
- **`timeout`:** high for exactly the one cycle in which `en` first reads 0 after a forced release; otherwise 0.
- **Simultaneous events:**
  - `done=1` (or `req[g]=0`) together with `cnt == HOLD_MAX-1` is a normal release: `timeout` stays 0.
  - `rst` overrides everything. Reset during GRANT gives `en=0` and `last=3` at that edge; `timeout` is not pulsed.
- **Counter width:** `cnt` is CW bits and never wraps, because release happens at `HOLD_MAX-1`.

## Timing
- **Request to grant:** `req` sampled in IDLE at edge N gives `en=1` with a valid `{a,b}` after edge N.
- **Release:** `done` sampled at edge M gives `en=0` after edge M. The earliest next grant is `en=1` after edge M+1, so there is always at least one `en=0` cycle between grants.
- **Maximum grant length:** exactly `HOLD_MAX` cycles of `en=1` when `done` never arrives.
- **Stability:** `{a,b}` changes only on the edge that sets `en=1`, never while `en=1`.
- **Steady-state throughput:** with continuous requests and `done` asserted in the first grant cycle, one grant every 2 cycles.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `req=1111` → `a=0`, `b=0`, `en=0`, `busy=0`, `timeout=0` throughout. After release, the first grant is index 0 (`a=0`, `b=0`, `en=1`) one cycle later.
- **Sparse requests:** after reset, hold `req=1010` and pulse `done` in each grant cycle → grant index 1 (`ab=01`), one `en=0` bubble, then index 3 (`ab=11`), then index 1 again.
- **Full rotation:** hold `req=1111` and pulse `done` in each grant → grant order 0, 1, 2, 3, 0 with the pattern `en`=1,0,1,0,… and decoder `y`=0001, 0000, 0010, 0000, 0100, …
- **Timeout:** with `HOLD_MAX=15`, hold `req=0100` and never assert `done` → `en` high for exactly 15 cycles, `timeout=1` for 1 cycle as `en` falls, then index 2 is re-granted after the bubble.
- **Coincident release:** assert `done` in the 15th grant cycle (`cnt=14`) → `en` falls and `timeout` stays 0. Separately, drop `req[g]` mid-grant → release with no timeout.
- **Reset mid-grant:** assert `rst` for 1 cycle while index 2 is granted with `req=1111` → `en=0` and `ab=00` after that edge, and the next grant is index 0.

Source files
------------

// File: rtl/rr_sel24_if.sv
// Request/grant bundle between the requesters and the round-robin sequencer.
// The sequencer drives {a,b,en}, which feed a 2:4 decoder that produces the per-requester grants.
interface rr_sel24_if;
  logic [3:0] req;
  logic       done;
  logic       a;
  logic       b;
  logic       en;
  logic       busy;
  logic       timeout;

  // Handshake: requester i holds req[i] high until served. While en=1, {a,b} names
  // the owner. The owner ends the grant by pulsing done or by dropping its req bit.
  modport master (output req, output done,
                  input  a, input b, input en, input busy, input timeout);
  modport slave  (input  req, input done,
                  output a, output b, output en, output busy, output timeout);
endinterface

// File: rtl/rr_sel24.sv
// Four-way round-robin select sequencer driving a 2:4 one-hot decoder's a/b/en.
// Grants are separated by at least one en=0 cycle, and {a,b} only changes as en rises.
module rr_sel24 #(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  rr_sel24_if.slave  bus,
  output logic       state_o
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    last_q;
  logic [1:0]    idx_q;
  logic          en_q;
  logic          timeout_q;

  logic [1:0]    pick;
  logic          any_req;

  // Scan from the farthest candidate down, so the nearest active index after last_q wins.
  always_comb begin
    pick = last_q;
    for (int k = 3; k >= 1; k--) begin
      if (bus.req[last_q + 2'(k)]) pick = last_q + 2'(k);
    end
  end

  assign any_req = |bus.req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 2'd3;
      idx_q     <= 2'd0;
      en_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            idx_q   <= pick;
            en_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_GRANT;
          end else begin
            en_q <= 1'b0;
          end
        end
        S_GRANT: begin
          if (bus.done || !bus.req[idx_q]) begin
            en_q    <= 1'b0;
            last_q  <= idx_q;
            state_q <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            en_q      <= 1'b0;
            last_q    <= idx_q;
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.a       = idx_q[1];
  assign bus.b       = idx_q[0];
  assign bus.en      = en_q;
  assign bus.busy    = en_q;
  assign bus.timeout = timeout_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_rr_sel24.sv
// Bench for rr_sel24: directed scenarios plus random traffic, scored against a
// grant-level reference model that tracks owner, grant length and last owner.
module tb_rr_sel24;
  localparam int HOLD_MAX = 15;

  logic clk;
  logic rst;
  logic state_o;
  rr_sel24_if bus ();

  rr_sel24 #(.HOLD_MAX(HOLD_MAX), .CW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
  end

  // scoreboard
  int n_chk  = 0;
  int n_pass = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // reference model: grant-level view of the sequencer
  bit m_busy  = 0;
  int m_owner = 0;
  int m_len   = 0;   // cycles the current grant has lasted so far
  int m_last  = 3;
  bit m_to    = 0;

  task automatic model_step(input bit r, input logic [3:0] rq, input bit d);
    bit found;
    int cand;
    m_to = 0;
    if (r) begin
      m_busy = 0; m_owner = 0; m_len = 0; m_last = 3;
    end else if (!m_busy) begin
      if (rq != 4'b0000) begin
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          cand = (m_last + k) % 4;
          if (!found && rq[cand]) begin
            m_owner = cand;
            found   = 1;
          end
        end
        m_busy = 1;
        m_len  = 1;
      end
    end else begin
      if (d || !rq[m_owner]) begin
        m_busy = 0; m_last = m_owner;
      end else if (m_len == HOLD_MAX) begin
        m_busy = 0; m_last = m_owner; m_to = 1;
      end else begin
        m_len++;
      end
    end
  endtask

  // driver: apply inputs on the falling edge, score after the rising edge
  task automatic cycle(input bit r, input logic [3:0] rq, input bit d);
    logic [4:0] exp;
    logic [4:0] got;
    @(negedge clk);
    rst      = r;
    bus.req  = rq;
    bus.done = d;
    model_step(r, rq, d);
    exp_q.push_back({2'(m_owner), m_busy, m_busy, m_to});
    @(posedge clk);
    #1;
    got = {bus.a, bus.b, bus.en, bus.busy, bus.timeout};
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check("outputs", 32'(got), 32'(exp));
      check("state", 32'(state_o), 32'(exp[2]));
    end
  endtask

  // release done in every grant cycle the model says is active
  task automatic run_done_each(input logic [3:0] rq, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rq, m_busy);
  endtask

  initial begin
    // reset with all requests pending
    cycle(1'b1, 4'b1111, 1'b0);
    cycle(1'b1, 4'b1111, 1'b0);
    check("reset_out", 32'({bus.a, bus.b, bus.en, bus.busy, bus.timeout}), 32'd0);
    cycle(1'b0, 4'b1111, 1'b0);
    check("first_grant", 32'({bus.a, bus.b, bus.en}), 32'b001);

    // sparse requests 1010
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b1010, 1'b0);
    check("sparse_first", 32'({bus.a, bus.b, bus.en}), 32'b011);
    run_done_each(4'b1010, 6);

    // full rotation
    run_done_each(4'b1111, 10);

    // timeout on a lone requester
    while (m_busy) cycle(1'b0, 4'b1111, 1'b1);
    for (int i = 0; i < 2 * HOLD_MAX + 4; i++) cycle(1'b0, 4'b0100, 1'b0);

    // done coincident with the final allowed cycle
    while (m_busy) cycle(1'b0, 4'b0100, 1'b1);
    for (int i = 0; i < HOLD_MAX + 3; i++)
      cycle(1'b0, 4'b0100, m_busy && (m_len == HOLD_MAX));

    // owner drops its request mid-grant
    while (m_busy) cycle(1'b0, 4'b0100, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    check("drop_release", 32'({bus.en, bus.timeout}), 32'b00);
    cycle(1'b0, 4'b0000, 1'b0);

    // reset while index 2 owns the grant
    for (int i = 0; i < 20 && !(m_busy && m_owner == 2); i++)
      cycle(1'b0, 4'b1111, m_busy);
    check("reach_owner2", 32'({bus.a, bus.b, bus.en}), 32'b101);
    cycle(1'b1, 4'b1111, 1'b0);
    check("mid_reset", 32'({bus.a, bus.b, bus.en, bus.timeout}), 32'b0000);
    cycle(1'b0, 4'b1111, 1'b0);
    check("post_reset_grant", 32'({bus.a, bus.b, bus.en}), 32'b001);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] rq;
      bit d, r;
      rq = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 99) == 0);
      if (m_busy && $urandom_range(0, 3) != 0) rq[m_owner] = 1'b1;
      cycle(r, rq, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
